// File: rtl/cpu_pkg.sv
// Shared opcode/state types and default widths for the register-file access sequencer.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_MOV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ_A = 3'd1,
    ST_READ_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WRITE  = 3'd4
  } state_e;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: ADD/SUB/AND/MOV with carry-out (ADD) or borrow (SUB).
module seq_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // The extra top bit of the widened difference is set exactly when a < b.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  // Operation select
  always_comb begin
    result = {DATA_W{1'b0}};
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = w_sum[DATA_W-1:0];
        carry  = w_sum[DATA_W];
      end
      OP_SUB: begin
        result = w_diff[DATA_W-1:0];
        carry  = w_diff[DATA_W];
      end
      OP_AND: begin
        result = a & b;
        carry  = 1'b0;
      end
      OP_MOV: begin
        result = a;
        carry  = 1'b0;
      end
      default: begin
        result = {DATA_W{1'b0}};
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_access_sequencer.sv
// Five-state sequencer: read two registers, execute one ALU op, write the result back.
// Optional zero/carry flag outputs are enabled by defining REGFILE_SEQ_FLAGS_EN.
module regfile_access_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_src_a,
  input  logic [ADDR_W-1:0] req_src_b,
  input  logic [ADDR_W-1:0] req_dest,
  output logic [ADDR_W-1:0] rf_read_address,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [ADDR_W-1:0] rf_write_address,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  output logic              done
`ifdef REGFILE_SEQ_FLAGS_EN
  ,
  output logic              zero_flag,
  output logic              carry_flag
`endif
);

  state_e            r_state;
  state_e            w_state_next;
  op_e               r_op;
  logic [ADDR_W-1:0] r_src_a;
  logic [ADDR_W-1:0] r_src_b;
  logic [ADDR_W-1:0] r_dest;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (r_op),
    .a      (r_op_a),
    .b      (r_op_b),
    .result (w_alu_result),
    .carry  (w_alu_carry)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_state_next = req_valid ? ST_READ_A : ST_IDLE;
      ST_READ_A: w_state_next = ST_READ_B;
      ST_READ_B: w_state_next = ST_EXEC;
      ST_EXEC:   w_state_next = ST_WRITE;
      ST_WRITE:  w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Output decode; the read port rests on src_a outside READ_B
  always_comb begin
    req_ready       = 1'b0;
    rf_read_address = r_src_a;
    rf_write_enable = 1'b0;
    done            = 1'b0;
    case (r_state)
      ST_IDLE:   req_ready = 1'b1;
      ST_READ_B: rf_read_address = r_src_b;
      ST_WRITE: begin
        rf_write_enable = 1'b1;
        done            = 1'b1;
      end
      default:   req_ready = 1'b0;
    endcase
  end

  assign rf_write_address = r_dest;
  assign rf_write_data    = r_result;

  // Request latch, operand capture and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= OP_ADD;
      r_src_a  <= {ADDR_W{1'b0}};
      r_src_b  <= {ADDR_W{1'b0}};
      r_dest   <= {ADDR_W{1'b0}};
      r_op_a   <= {DATA_W{1'b0}};
      r_op_b   <= {DATA_W{1'b0}};
      r_result <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op    <= op_e'(req_op);
            r_src_a <= req_src_a;
            r_src_b <= req_src_b;
            r_dest  <= req_dest;
          end
        end
        ST_READ_A: r_op_a   <= rf_read_data;
        ST_READ_B: r_op_b   <= rf_read_data;
        ST_EXEC:   r_result <= w_alu_result;
        default:   r_result <= r_result;
      endcase
    end
  end

`ifdef REGFILE_SEQ_FLAGS_EN
  logic r_zero;
  logic r_carry;

  // Flags follow the result registered in EXEC and hold until the next EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_zero  <= (w_alu_result == {DATA_W{1'b0}});
      r_carry <= w_alu_carry;
    end
  end

  assign zero_flag  = r_zero;
  assign carry_flag = r_carry;
`else
  logic w_unused_alu_carry;
  assign w_unused_alu_carry = w_alu_carry;
`endif

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Self-checking bench for regfile_access_sequencer: directed cases plus random ops against a register-file model.
module tb_regfile_access_sequencer;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_src_a, req_src_b, req_dest;
  logic [AW-1:0] rf_read_address;
  logic [DW-1:0] rf_read_data;
  logic [AW-1:0] rf_write_address;
  logic [DW-1:0] rf_write_data;
  logic          rf_write_enable;
  logic          done;
`ifdef REGFILE_SEQ_FLAGS_EN
  logic          zero_flag, carry_flag;
`endif

  logic [DW-1:0] rf [4];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  int unsigned mrf [4];
  bit          mzero, mcarry;
  int          checks = 0;
  int          errors = 0;

  regfile_access_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_src_a        (req_src_a),
    .req_src_b        (req_src_b),
    .req_dest         (req_dest),
    .rf_read_address  (rf_read_address),
    .rf_read_data     (rf_read_data),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .rf_write_enable  (rf_write_enable),
    .done             (done)
`ifdef REGFILE_SEQ_FLAGS_EN
    ,
    .zero_flag        (zero_flag),
    .carry_flag       (carry_flag)
`endif
  );

  always #5 clk = ~clk;

  // Register file seen by the DUT; preload port used only while the DUT is idle
  assign rf_read_data = rf[rf_read_address];
  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (rf_write_enable) rf[rf_write_address] <= rf_write_data;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_op(input int op, input int a, input int b,
                                   output int res, output bit c);
    case (op)
      0:       begin res = (a + b) % 256;       c = (a + b) > 255; end
      1:       begin res = (a - b + 256) % 256; c = (a < b);       end
      2:       begin res = a & b;               c = 1'b0;          end
      default: begin res = a;                   c = 1'b0;          end
    endcase
  endfunction

  task automatic check_flags(input string tag);
`ifdef REGFILE_SEQ_FLAGS_EN
    check({tag, "_zero"},  zero_flag,  mzero);
    check({tag, "_carry"}, carry_flag, mcarry);
`endif
  endtask

  // Entered and left at a falling edge
  task automatic preload(input int a, input int v);
    pre_we = 1'b1; pre_addr = a[1:0]; pre_data = v[7:0];
    @(posedge clk);
    @(negedge clk);
    pre_we = 1'b0;
    mrf[a] = v;
  endtask

  // One full request with cycle-by-cycle checks; entered and left at a falling edge
  task automatic do_op(input int op, input int sa, input int sb, input int d, input string tag);
    int res;
    bit c;
    int waitc;
    model_op(op, mrf[sa], mrf[sb], res, c);
    waitc = 0;
    while (!req_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "_ready_idle"}, req_ready, 1'b1);
    req_valid = 1'b1; req_op = op[1:0];
    req_src_a = sa[1:0]; req_src_b = sb[1:0]; req_dest = d[1:0];
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_rda"},      rf_read_address, sa);
    check({tag, "_ready_busy"}, req_ready,     1'b0);
    check({tag, "_we_ra"},    rf_write_enable, 1'b0);
    @(negedge clk);
    check({tag, "_rdb"},      rf_read_address, sb);
    check({tag, "_we_rb"},    rf_write_enable, 1'b0);
    @(negedge clk);
    check({tag, "_rd_exec"},  rf_read_address, sa);
    check({tag, "_done_ex"},  done,            1'b0);
    @(negedge clk);
    mrf[d] = res; mzero = (res == 0); mcarry = c;
    check({tag, "_we"},       rf_write_enable, 1'b1);
    check({tag, "_done"},     done,            1'b1);
    check({tag, "_waddr"},    rf_write_address, d);
    check({tag, "_wdata"},    rf_write_data,   res);
    check_flags({tag, "_wr"});
    @(negedge clk);
    check({tag, "_we_after"},   rf_write_enable, 1'b0);
    check({tag, "_done_after"}, done,            1'b0);
    check({tag, "_ready_back"}, req_ready,       1'b1);
    check_flags({tag, "_hold"});
  endtask

  initial begin
    int ndone;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00;
    req_src_a = '0; req_src_b = '0; req_dest = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    mzero = 1'b0; mcarry = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready,        1'b1);
    check("rst_we",    rf_write_enable,  1'b0);
    check("rst_done",  done,             1'b0);
    check("rst_raddr", rf_read_address,  2'd0);
    check("rst_waddr", rf_write_address, 2'd0);
    check("rst_wdata", rf_write_data,    8'd0);
    check_flags("rst");
    reset = 1'b0;

    for (int i = 0; i < 4; i++) preload(i, 0);
    preload(1, 8'h05); preload(2, 8'h03);
    do_op(0, 1, 2, 3, "add");
    preload(1, 8'h03); preload(2, 8'h05);
    do_op(1, 1, 2, 0, "sub");
    preload(1, 8'hFF);
    do_op(0, 1, 1, 1, "add_wrap");
    preload(1, 8'hF0); preload(2, 8'h0F);
    do_op(2, 1, 2, 3, "and_zero");

    // Continuous req_valid: three back-to-back accepts R0 += R1
    preload(0, 8'h10); preload(1, 8'h07);
    req_op = 2'b00; req_src_a = 2'd0; req_src_b = 2'd1; req_dest = 2'd0;
    req_valid = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      check("b2b_ready", req_ready, (i % 5 == 0));
      check("b2b_done",  done,      (i % 5 == 4));
      if (done) ndone++;
      if (i % 5 == 4) begin
        mrf[0] = (mrf[0] + mrf[1]) % 256;
        mzero = (mrf[0] == 0); mcarry = 1'b0;
        check("b2b_wdata", rf_write_data, mrf[0]);
      end
      if (i == 14) req_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_ndone", ndone, 3);
    check_flags("b2b");

    // Reset during EXEC of MOV R2->R0 must abandon the write-back
    preload(2, 8'h5A);
    req_valid = 1'b1; req_op = 2'b11; req_src_a = 2'd2; req_src_b = 2'd1; req_dest = 2'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mzero = 1'b0; mcarry = 1'b0;
    check("mrst_we",    rf_write_enable, 1'b0);
    check("mrst_ready", req_ready,       1'b1);
    check("mrst_raddr", rf_read_address, 2'd0);
    check("mrst_wdata", rf_write_data,   8'd0);
    check_flags("mrst");
    @(negedge clk);
    check("mrst_ready_after", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("mrst_no_we", rf_write_enable, 1'b0);
      @(negedge clk);
    end
    check("mrst_r0_kept", rf[0], mrf[0]);

    // Random operations against the model
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(1, 0) == 1) preload($urandom_range(3, 0), $urandom_range(255, 0));
      do_op($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
            $urandom_range(3, 0), "rnd");
    end

    for (int i = 0; i < 4; i++) check("rf_final", rf[i], mrf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_access_sequencer.md
REGFILE_ACCESS_SEQUENCER -- requirements
Module: regfile_access_sequencer

Interface
REQ-001 SHALL take parameter DATA_W, default 8, register and operand width.
REQ-002 SHALL take parameter ADDR_W, default 2, register address width (4 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have port req_op  input  2  operation: 00 ADD, 01 SUB, 10 AND, 11 MOV.
REQ-008 SHALL have ports req_src_a, req_src_b, req_dest  input  ADDR_W each  operand and destination register addresses.
REQ-009 SHALL have port rf_read_address  output  ADDR_W  register-file read address.
REQ-010 SHALL have port rf_read_data  input  DATA_W  register-file read data, combinational from rf_read_address.
REQ-011 SHALL have ports rf_write_address  output  ADDR_W, rf_write_data  output  DATA_W, and rf_write_enable  output  1  register-file write port.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a write-back is issued.

Function
REQ-013 SHALL implement FSM states IDLE, READ_A, READ_B, EXEC, WRITE.
REQ-014 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge where req_valid && req_ready, latching op, src_a, src_b, dest, then moving to READ_A.
REQ-015 SHALL in READ_A drive rf_read_address=src_a and capture rf_read_data into op_a at cycle end, then move to READ_B.
REQ-016 SHALL in READ_B drive rf_read_address=src_b and capture rf_read_data into op_b, then move to EXEC.
REQ-017 SHALL in EXEC register result: ADD op_a+op_b mod 2^DATA_W; SUB op_a-op_b mod 2^DATA_W; AND op_a&op_b; MOV op_a (op_b ignored); then move to WRITE.
REQ-018 SHALL in WRITE drive rf_write_enable=1, rf_write_address=dest, rf_write_data=result, done=1, then return to IDLE.
REQ-019 SHALL keep rf_write_enable and done low in every state other than WRITE.
REQ-020 SHALL give a fixed latency: accept at edge k, rf_write_enable high during cycle k+4; next accept no earlier than edge k+5.
REQ-021 SHALL handle dest equal to src_a or src_b correctly: operands are read before write-back.
REQ-022 SHALL hold rf_read_address at src_a in IDLE, EXEC, and WRITE.

Reset
REQ-023 SHALL on reset go to IDLE and clear op_a, op_b, result, and latched fields to 0; outputs: req_ready=1 after the reset edge, rf_write_enable=0, done=0, rf_read_address=0, rf_write_address=0, rf_write_data=0.
REQ-024 SHALL on reset asserted mid-operation, including WRITE, abandon the operation with no write-back issued in the following cycle; reset takes priority over request acceptance.

Configuration
REQ-025 SHALL with macro REGFILE_SEQ_FLAGS_EN defined add outputs zero_flag (1) and carry_flag (1), both registered in EXEC: zero = (result==0); carry = carry-out for ADD, borrow (op_a<op_b) for SUB, 0 for AND/MOV; both hold between operations and are reset to 0.
REQ-026 SHALL without REGFILE_SEQ_FLAGS_EN omit the flag ports and their logic entirely.

Structure
REQ-027 SHALL place the opcode enum, FSM state enum, and default DATA_W/ADDR_W constants in shared package cpu_pkg.
REQ-028 SHALL implement the arithmetic in one combinational sub-module seq_alu (inputs op, a, b; outputs result, carry); the FSM stays in the top module.

Verification
REQ-029 SHALL cover this case: registers preloaded as R1=0x05 and R2=0x03; ADD src1,src2->dest3 -> R3=0x08 written at cycle k+4, done pulses once.
REQ-030 SHALL cover this case: R1=0x03 and R2=0x05; SUB->R0 -> R0=0xFE; with REGFILE_SEQ_FLAGS_EN, carry_flag=1 and zero_flag=0.
REQ-031 SHALL cover this case: R1=0xFF; ADD R1,R1->R1 -> R1=0xFE (wrap); carry_flag=1; read of src_b sees the old 0xFF.
REQ-032 SHALL cover this case: req_valid held high continuously for 3 requests -> req_ready high only in IDLE, accepts spaced exactly 5 cycles, 3 done pulses.
REQ-033 SHALL cover this case: reset asserted during EXEC of MOV R2->R0 -> no rf_write_enable ever for that request, req_ready=1 the cycle after reset deasserts.
REQ-034 SHALL cover this case: AND with R1=0xF0 and R2=0x0F -> result 0x00 written; zero_flag=1.
